// File: rtl/sic_exec_mem_subword_if.sv
// Bundle between the memory-execution SIC and its neighbours: dispatcher, operand network, ECR table,
// memory arbiter and the GPR/exception sinks.
interface sic_exec_mem_subword_if #(
  parameter int ID_WIDTH     = 8,
  parameter int ECR_ID_WIDTH = 1
);
  logic                    req_instr;
  logic                    pkt_valid;
  logic [ID_WIDTH-1:0]     pkt_issue_id;
  logic [ECR_ID_WIDTH:0]   pkt_dep_ecr;
  logic                    pkt_mem_read;
  logic                    pkt_mem_write;
  logic [1:0]              pkt_size;
  logic                    pkt_unsigned;
  logic                    pkt_write_gpr;
  logic [31:0]             pkt_imm;
  logic                    rs_valid;
  logic                    rt_valid;
  logic [31:0]             rs_rdata;
  logic [31:0]             rt_rdata;
  logic                    ecr_read_en;
  logic [ECR_ID_WIDTH-1:0] ecr_read_addr;
  logic [1:0]              ecr_read_data;
  logic                    mem_req;
  logic                    mem_release;
  logic [ID_WIDTH-1:0]     mem_req_issue_id;
  logic                    mem_grant;
  logic [29:0]             mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_wstrb;
  logic                    mem_wen;
  logic [31:0]             mem_rdata;
  logic [31:0]             reg_wdata;
  logic                    reg_wcommit;
  logic                    exc_valid;
  logic [ID_WIDTH-1:0]     exc_issue_id;
  logic [31:0]             exc_badvaddr;

  modport master (
    input  req_instr, ecr_read_en, ecr_read_addr, mem_req, mem_release, mem_req_issue_id,
           mem_addr, mem_wdata, mem_wstrb, mem_wen, reg_wdata, reg_wcommit,
           exc_valid, exc_issue_id, exc_badvaddr,
    output pkt_valid, pkt_issue_id, pkt_dep_ecr, pkt_mem_read, pkt_mem_write, pkt_size,
           pkt_unsigned, pkt_write_gpr, pkt_imm, rs_valid, rt_valid, rs_rdata, rt_rdata,
           ecr_read_data, mem_grant, mem_rdata
  );

  modport slave (
    output req_instr, ecr_read_en, ecr_read_addr, mem_req, mem_release, mem_req_issue_id,
           mem_addr, mem_wdata, mem_wstrb, mem_wen, reg_wdata, reg_wcommit,
           exc_valid, exc_issue_id, exc_badvaddr,
    input  pkt_valid, pkt_issue_id, pkt_dep_ecr, pkt_mem_read, pkt_mem_write, pkt_size,
           pkt_unsigned, pkt_write_gpr, pkt_imm, rs_valid, rt_valid, rs_rdata, rt_rdata,
           ecr_read_data, mem_grant, mem_rdata
  );
endinterface

// File: rtl/sic_exec_mem_subword.sv
// Single-issue load/store executor with sub-word lanes, sign/zero extension and alignment traps.
//   state | meaning
//   IDLE  | waiting for a packet
//   LOCK  | packet latched, waiting for operands
//   ADDR  | effective address computed, waiting for the dependency ECR to resolve
//   MEM   | arbiter request outstanding, access performed on grant
//   EXC   | one-cycle address-error report
module sic_exec_mem_subword #(
  parameter int SIC_ID       = 0,
  parameter int ID_WIDTH     = 8,
  parameter int ECR_ID_WIDTH = 1,
  parameter int SUBWORD_EN   = 1
) (
  input logic clk,
  input logic rst_n,
  sic_exec_mem_subword_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOCK = 3'd1;
  localparam logic [2:0] ADDR = 3'd2;
  localparam logic [2:0] MEM  = 3'd3;
  localparam logic [2:0] EXC  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [ID_WIDTH-1:0]     issue_id_q, issue_id_d;
  logic [ECR_ID_WIDTH:0]   dep_q, dep_d;
  logic                    rd_q, rd_d, wr_q, wr_d, uns_q, uns_d, wgpr_q, wgpr_d;
  logic [1:0]              size_q, size_d;
  logic [31:0]             imm_q, imm_d, ea_q, ea_d, rt_q, rt_d;

  logic        dep_valid, abort, ecr_ok, misaligned, in_mem, is_load;
  logic [1:0]  eff_size;
  logic [31:0] ea_calc, lane;

  always_comb begin
    dep_valid  = dep_q[ECR_ID_WIDTH];
    abort      = (state_q != IDLE) && dep_valid && (bus.ecr_read_data == 2'b10);
    ecr_ok     = !dep_valid || (bus.ecr_read_data == 2'b01);
    eff_size   = (SUBWORD_EN != 0) ? size_q : 2'b10;
    ea_calc    = bus.rs_rdata + imm_q;
    case (eff_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ea_calc[0];
      default: misaligned = (ea_calc[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    issue_id_d = issue_id_q;
    dep_d      = dep_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    uns_d      = uns_q;
    wgpr_d     = wgpr_q;
    size_d     = size_q;
    imm_d      = imm_q;
    ea_d       = ea_q;
    rt_d       = rt_q;
    case (state_q)
      IDLE: if (bus.pkt_valid) begin
        state_d    = LOCK;
        issue_id_d = bus.pkt_issue_id;
        dep_d      = bus.pkt_dep_ecr;
        rd_d       = bus.pkt_mem_read;
        wr_d       = bus.pkt_mem_write;
        uns_d      = bus.pkt_unsigned;
        wgpr_d     = bus.pkt_write_gpr;
        size_d     = bus.pkt_size;
        imm_d      = bus.pkt_imm;
      end
      LOCK: if (bus.rs_valid && (!wr_q || bus.rt_valid)) state_d = ADDR;
      ADDR: begin
        // Recomputed every cycle while the ECR is busy so late operand updates are picked up.
        ea_d = ea_calc;
        rt_d = bus.rt_rdata;
        if (ecr_ok) state_d = misaligned ? EXC : MEM;
      end
      MEM:     if (bus.mem_grant) state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issue_id_q <= '0;
      dep_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      wgpr_q     <= 1'b0;
      size_q     <= 2'b00;
      imm_q      <= '0;
      ea_q       <= '0;
      rt_q       <= '0;
    end else begin
      state_q    <= state_d;
      issue_id_q <= issue_id_d;
      dep_q      <= dep_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      uns_q      <= uns_d;
      wgpr_q     <= wgpr_d;
      size_q     <= size_d;
      imm_q      <= imm_d;
      ea_q       <= ea_d;
      rt_q       <= rt_d;
    end
  end

  always_comb begin
    in_mem  = (state_q == MEM);
    is_load = rd_q && !wr_q;
    lane    = bus.mem_rdata >> {ea_q[1:0], 3'b000};

    bus.req_instr        = (state_q == IDLE) && !bus.pkt_valid;
    bus.ecr_read_en      = (state_q != IDLE) && dep_valid;
    bus.ecr_read_addr    = dep_q[ECR_ID_WIDTH-1:0];
    bus.mem_req          = in_mem;
    bus.mem_release      = in_mem && bus.mem_grant;
    bus.mem_req_issue_id = issue_id_q;
    bus.mem_addr         = ea_q[31:2];
    bus.mem_wen          = in_mem && wr_q && bus.mem_grant && !abort;
    bus.reg_wcommit      = in_mem && is_load && bus.mem_grant && wgpr_q && !abort;
    bus.exc_valid        = (state_q == EXC) && !abort;
    bus.exc_issue_id     = issue_id_q;
    bus.exc_badvaddr     = ea_q;

    bus.mem_wdata = '0;
    bus.mem_wstrb = 4'b0000;
    if (in_mem && wr_q) begin
      case (eff_size)
        2'b00: begin
          bus.mem_wdata = {4{rt_q[7:0]}};
          bus.mem_wstrb = 4'b0001 << ea_q[1:0];
        end
        2'b01: begin
          bus.mem_wdata = {2{rt_q[15:0]}};
          bus.mem_wstrb = ea_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          bus.mem_wdata = rt_q;
          bus.mem_wstrb = 4'b1111;
        end
      endcase
    end

    bus.reg_wdata = '0;
    if (in_mem && is_load) begin
      case (eff_size)
        2'b00:   bus.reg_wdata = {{24{!uns_q && lane[7]}}, lane[7:0]};
        2'b01:   bus.reg_wdata = {{16{!uns_q && lane[15]}}, lane[15:0]};
        default: bus.reg_wdata = bus.mem_rdata;
      endcase
    end
  end
endmodule

// File: tb/tb_sic_exec_mem_subword.sv
// Directed-vector bench for sic_exec_mem_subword; every expected value is hand-computed.
module tb_sic_exec_mem_subword;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sic_exec_mem_subword_if #(.ID_WIDTH(8), .ECR_ID_WIDTH(1)) bus ();

  sic_exec_mem_subword #(.SIC_ID(0), .ID_WIDTH(8), .ECR_ID_WIDTH(1), .SUBWORD_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] id, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] imm, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [1:0] dep);
    bus.pkt_valid     = 1'b1;
    bus.pkt_issue_id  = id;
    bus.pkt_mem_read  = rd;
    bus.pkt_mem_write = wr;
    bus.pkt_size      = sz;
    bus.pkt_unsigned  = uns;
    bus.pkt_imm       = imm;
    bus.pkt_dep_ecr   = dep;
    bus.rs_rdata      = rs;
    bus.rt_rdata      = rt;
    bus.rs_valid      = 1'b1;
    bus.rt_valid      = 1'b1;
    #1 chk("req_instr_on_pkt", bus.req_instr, 0);
    tick;
    bus.pkt_valid = 1'b0;
  endtask

  task automatic wait_req;
    for (int i = 0; i < 12 && !bus.mem_req; i++) tick;
    chk("mem_req_seen", bus.mem_req, 1);
  endtask

  initial begin
    bus.pkt_valid = 0; bus.pkt_issue_id = 0; bus.pkt_dep_ecr = 0; bus.pkt_mem_read = 0;
    bus.pkt_mem_write = 0; bus.pkt_size = 0; bus.pkt_unsigned = 0; bus.pkt_write_gpr = 1;
    bus.pkt_imm = 0; bus.rs_valid = 0; bus.rt_valid = 0; bus.rs_rdata = 0; bus.rt_rdata = 0;
    bus.ecr_read_data = 0; bus.mem_grant = 0; bus.mem_rdata = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_instr", bus.req_instr, 1);
    chk("rst_mem_req", {bus.mem_req, bus.mem_release, bus.mem_wen, bus.reg_wcommit, bus.exc_valid, bus.ecr_read_en}, 0);
    chk("rst_wstrb", bus.mem_wstrb, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_reg_wdata", bus.reg_wdata, 0);
    chk("rst_badvaddr", bus.exc_badvaddr, 0);
    rst_n = 1'b1;
    tick;

    // LB ea=0x1003, top byte 0x80 sign-extends
    issue(8'h11, 1, 0, 2'b00, 0, 32'd3, 32'h1000, 32'h0, 2'b00);
    chk("lb_lock_no_req", bus.mem_req, 0);
    wait_req;
    chk("lb_no_commit_before_grant", bus.reg_wcommit, 0);
    bus.mem_rdata = 32'h80FF_FF00;
    bus.mem_grant = 1'b1;
    #1;
    chk("lb_commit", bus.reg_wcommit, 1);
    chk("lb_wdata", bus.reg_wdata, 32'hFFFF_FF80);
    chk("lb_release", bus.mem_release, 1);
    chk("lb_addr", bus.mem_addr, 30'h400);
    chk("lb_wen", bus.mem_wen, 0);
    chk("lb_issue_id", bus.mem_req_issue_id, 8'h11);
    tick;
    bus.mem_grant = 1'b0;
    #1;
    chk("lb_done_req", bus.mem_req, 0);
    chk("lb_done_ready", bus.req_instr, 1);

    // LBU, dependent on ECR 0 resolved correct
    bus.ecr_read_data = 2'b01;
    issue(8'h12, 1, 0, 2'b00, 1, 32'd3, 32'h1000, 32'h0, 2'b10);
    wait_req;
    chk("lbu_ecr_en", bus.ecr_read_en, 1);
    bus.mem_grant = 1'b1;
    #1;
    chk("lbu_wdata", bus.reg_wdata, 32'h0000_0080);
    chk("lbu_commit", bus.reg_wcommit, 1);
    tick;
    bus.mem_grant = 1'b0;
    bus.ecr_read_data = 2'b00;

    // SH ea=0x2002, rt arrives late
    issue(8'h22, 0, 1, 2'b01, 0, 32'd2, 32'h2000, 32'h1234_ABCD, 2'b00);
    bus.rt_valid = 1'b0;
    tick;
    tick;
    chk("sh_wait_rt", bus.mem_req, 0);
    bus.rt_valid = 1'b1;
    wait_req;
    chk("sh_wen_pre_grant", bus.mem_wen, 0);
    bus.mem_grant = 1'b1;
    #1;
    chk("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
    chk("sh_addr", bus.mem_addr, 30'h800);
    chk("sh_wen", bus.mem_wen, 1);
    chk("sh_commit", bus.reg_wcommit, 0);
    tick;
    bus.mem_grant = 1'b0;
    #1;
    chk("sh_wen_drop", bus.mem_wen, 0);

    // LW at 0x1001 traps
    issue(8'h33, 1, 0, 2'b10, 0, 32'd1, 32'h1000, 32'h0, 2'b00);
    tick;
    chk("lw_addr_no_req", bus.mem_req, 0);
    tick;
    chk("lw_exc", bus.exc_valid, 1);
    chk("lw_badvaddr", bus.exc_badvaddr, 32'h1001);
    chk("lw_exc_id", bus.exc_issue_id, 8'h33);
    chk("lw_exc_no_req", bus.mem_req, 0);
    tick;
    chk("lw_exc_pulse", bus.exc_valid, 0);
    chk("lw_idle", bus.req_instr, 1);
    chk("lw_no_req_after", bus.mem_req, 0);

    // Dependency on ECR 1: busy, then incorrect
    bus.ecr_read_data = 2'b00;
    issue(8'h44, 1, 0, 2'b10, 0, 32'h0, 32'h100, 32'h0, 2'b11);
    chk("ecr_en", bus.ecr_read_en, 1);
    chk("ecr_addr", bus.ecr_read_addr, 1);
    tick;
    tick;
    tick;
    chk("ecr_busy_no_req", bus.mem_req, 0);
    bus.ecr_read_data = 2'b10;
    #1;
    chk("ecr_abort_outs", {bus.mem_req, bus.exc_valid, bus.reg_wcommit, bus.mem_wen}, 0);
    tick;
    bus.ecr_read_data = 2'b00;
    #1;
    chk("ecr_abort_ready", bus.req_instr, 1);
    chk("ecr_abort_no_req", bus.mem_req, 0);
    chk("ecr_abort_en_off", bus.ecr_read_en, 0);

    // SW ea=0x3004 with grant withheld 5 cycles
    issue(8'h55, 0, 1, 2'b10, 0, 32'h4, 32'h3000, 32'hDEAD_BEEF, 2'b00);
    wait_req;
    begin
      int held;
      held = 0;
      for (int i = 0; i < 5; i++) begin
        if (bus.mem_req && !bus.mem_release && !bus.mem_wen) held++;
        tick;
      end
      chk("sw_req_held", held, 5);
    end
    bus.mem_grant = 1'b1;
    #1;
    chk("sw_release", bus.mem_release, 1);
    chk("sw_wstrb", bus.mem_wstrb, 4'b1111);
    chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("sw_wen", bus.mem_wen, 1);
    chk("sw_addr", bus.mem_addr, 30'hC01);
    tick;
    bus.mem_grant = 1'b0;

    // Reset while in MEM
    issue(8'h66, 1, 0, 2'b10, 0, 32'h0, 32'h40, 32'h0, 2'b00);
    wait_req;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req_drop", {bus.mem_req, bus.mem_release}, 0);
    chk("rst_mem_ready", bus.req_instr, 1);
    chk("rst_mem_addr", bus.mem_addr, 0);
    #1 rst_n = 1'b1;
    tick;

    // LHU ea=0x3002 and LH ea=0x3000 after reset
    issue(8'h77, 1, 0, 2'b01, 1, 32'h2, 32'h3000, 32'h0, 2'b00);
    wait_req;
    bus.mem_rdata = 32'hBEEF_0000;
    bus.mem_grant = 1'b1;
    #1;
    chk("lhu_wdata", bus.reg_wdata, 32'h0000_BEEF);
    chk("lhu_commit", bus.reg_wcommit, 1);
    tick;
    bus.mem_grant = 1'b0;
    issue(8'h78, 1, 0, 2'b01, 0, 32'h0, 32'h3000, 32'h0, 2'b00);
    wait_req;
    bus.mem_rdata = 32'h0000_8001;
    bus.mem_grant = 1'b1;
    #1;
    chk("lh_wdata", bus.reg_wdata, 32'hFFFF_8001);
    tick;
    bus.mem_grant = 1'b0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
